// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle unsigned integer divider. It uses restoring division and
// produces one quotient bit per clock. Requests use a start/done handshake.
//
// Parameters
//   WIDTH : operand, quotient and remainder width in bits (default 64)
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   start : division request, sampled only while idle (busy = 0)
//   a     : dividend, unsigned, sampled with start
//   b     : divisor, unsigned, sampled with start
//   busy  : high while a division is in flight (state != IDLE)
//   done  : one-cycle pulse; quo/rem/dbz are valid from this cycle onward
//   quo   : quotient  (all ones when dividing by zero)
//   rem   : remainder (the dividend when dividing by zero)
//   dbz   : divide-by-zero flag for the most recent result
//
// Timing
//   b != 0 : start sampled at E0, iterations on E1..E{WIDTH}, done in the
//            cycle after E{WIDTH}. Latency WIDTH+1, throughput WIDTH+2.
//   b == 0 : start sampled at E0, one non-iterating RUN cycle, done in the
//            cycle after E1. Latency 2.
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] quo_sr_r;    // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvsr_r;      // latched divisor
   // After every restoring step the partial remainder is below the divisor,
   // so it always fits in WIDTH bits. The extra top bit exists only
   // transiently in p_s and t_s.
   logic [WIDTH-1:0] prem_r;
   logic [CW-1:0]    cnt_r;       // iterations remaining
   logic             dbz_pend_r;  // request had b == 0; skip iterations

   logic [WIDTH:0]   p_s;
   logic [WIDTH:0]   t_s;
   logic [WIDTH-1:0] prem_nxt_s;
   logic [WIDTH-1:0] quo_nxt_s;

   // One restoring-division step: shift in the next dividend bit, then do a trial subtract.
   always_comb begin
      p_s        = {prem_r, quo_sr_r[WIDTH-1]};
      t_s        = p_s - {1'b0, dvsr_r};
      prem_nxt_s = p_s[WIDTH-1:0];
      quo_nxt_s  = {quo_sr_r[WIDTH-2:0], 1'b0};
      if (t_s[WIDTH] == 1'b0) begin
         // The trial subtract did not borrow. Keep the difference and set the quotient bit.
         prem_nxt_s = t_s[WIDTH-1:0];
         quo_nxt_s  = {quo_sr_r[WIDTH-2:0], 1'b1};
      end else begin
         // The trial subtract borrowed. p < divisor, so p[WIDTH] is 0 and can be dropped.
         prem_nxt_s = p_s[WIDTH-1:0];
         quo_nxt_s  = {quo_sr_r[WIDTH-2:0], 1'b0};
      end
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         quo_sr_r   <= {WIDTH{1'b0}};
         dvsr_r     <= {WIDTH{1'b0}};
         prem_r     <= {WIDTH{1'b0}};
         cnt_r      <= {CW{1'b0}};
         dbz_pend_r <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         quo        <= {WIDTH{1'b0}};
         rem        <= {WIDTH{1'b0}};
         dbz        <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state_r    <= ST_RUN;
                  busy       <= 1'b1;
                  quo_sr_r   <= a;
                  dvsr_r     <= b;
                  prem_r     <= {WIDTH{1'b0}};
                  cnt_r      <= CW'(WIDTH);
                  dbz_pend_r <= (b == {WIDTH{1'b0}});
               end else begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end

            ST_RUN: begin
               if (dbz_pend_r) begin
                  // Divide by zero: quo_sr_r still holds the dividend unchanged.
                  state_r    <= ST_FIN;
                  done       <= 1'b1;
                  quo        <= {WIDTH{1'b1}};
                  rem        <= quo_sr_r;
                  dbz        <= 1'b1;
                  dbz_pend_r <= 1'b0;
               end else begin
                  quo_sr_r <= quo_nxt_s;
                  prem_r   <= prem_nxt_s;
                  cnt_r    <= cnt_r - CW'(1);
                  if (cnt_r == CW'(1)) begin
                     // Last iteration: publish this step's results directly.
                     state_r <= ST_FIN;
                     done    <= 1'b1;
                     quo     <= quo_nxt_s;
                     rem     <= prem_nxt_s;
                     dbz     <= 1'b0;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
            end

            ST_FIN: begin
               // Any start seen in this state is ignored.
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end

            default: begin
               state_r    <= ST_IDLE;
               busy       <= 1'b0;
               done       <= 1'b0;
               dbz_pend_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
